// File: rtl/main_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : main_mem_ctrl
// Purpose  : Main-memory controller on the shared 16-bit execution-engine bus.
//            It responds when address[15:12] == SEL_ID and holds DEPTH rows of
//            DATA_W bits. Writes are lane-masked in LANE_W-bit lanes. Reads go
//            through a fixed READ_LAT-cycle pipeline and end in a MemValid
//            strobe. Every reset starts a clear sequence that zeroes all rows,
//            and Busy stays high until that sequence finishes.
// Option   : MAIN_MEM_FWD_EN - when defined, a read and a write to the same
//            row in the same cycle return the merged new row. When undefined,
//            such a read returns the row as it was before the write.
// Ports    : Clk         in   clock, rising edge
//            nReset      in   synchronous active-low reset
//            address     in   [15:12] block select, [11:0] row index
//            nRead       in   active-low read request
//            nWrite      in   active-low write request
//            ExeDataOut  in   write data (DATA_W)
//            LaneMask    in   per-lane write enables (DATA_W/LANE_W)
//            MemDataOut  out  read data, held between reads
//            MemValid    out  one-cycle strobe marking new MemDataOut
//            Busy        out  high during reset and the clear sequence
//            AddrErr     out  sticky out-of-range flag, cleared by reset
// Revision : 1.0 - initial release
// ============================================================================
module main_mem_ctrl #(
    parameter int         DATA_W   = 256,
    parameter int         LANE_W   = 16,
    parameter int         DEPTH    = 16,
    parameter logic [3:0] SEL_ID   = 4'd0,
    parameter int         READ_LAT = 2
) (
    input  logic                       Clk,
    input  logic                       nReset,
    input  logic [15:0]                address,
    input  logic                       nRead,
    input  logic                       nWrite,
    input  logic [DATA_W-1:0]          ExeDataOut,
    input  logic [DATA_W/LANE_W-1:0]   LaneMask,
    output logic [DATA_W-1:0]          MemDataOut,
    output logic                       MemValid,
    output logic                       Busy,
    output logic                       AddrErr
);

    localparam int c_NLANE = DATA_W / LANE_W;
    localparam int c_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_AW-1:0]     r_cnt;
    logic [DATA_W-1:0]   r_mem       [DEPTH];
    logic [DATA_W-1:0]   r_pipe_data [READ_LAT];
    logic [READ_LAT-1:0] r_pipe_vld;
    logic [DATA_W-1:0]   r_data_out;
    logic                r_valid;
    logic                r_addr_err;

    logic                w_busy;
    logic                w_sel;
    logic                w_rd;
    logic                w_wr;
    logic                w_in_range;
    logic                w_last;
    logic [c_AW-1:0]     w_row;
    logic [DATA_W-1:0]   w_row_data;
    logic [DATA_W-1:0]   w_merged;
    logic [DATA_W-1:0]   w_rd_data;

    // Request decode. Requests are only honoured in RUN.
    assign w_sel      = (address[15:12] == SEL_ID);
    assign w_rd       = ~nRead  & w_sel & (r_state == S_RUN);
    assign w_wr       = ~nWrite & w_sel & (r_state == S_RUN);
    assign w_in_range = (32'(address[11:0]) < 32'(DEPTH));
    assign w_row      = address[c_AW-1:0];
    assign w_last     = (32'(r_cnt) == 32'(DEPTH - 1));

    // Out-of-range rows read as zero and never index the array.
    assign w_row_data = w_in_range ? r_mem[w_row] : '0;

    // Row after applying the lane-masked write data.
    always_comb begin
        w_merged = w_row_data;
        for (int i = 0; i < c_NLANE; i++) begin
            if (LaneMask[i]) begin
                w_merged[i*LANE_W +: LANE_W] = ExeDataOut[i*LANE_W +: LANE_W];
            end
        end
    end

`ifdef MAIN_MEM_FWD_EN
    // A same-cycle write is forwarded into the read path.
    assign w_rd_data = (w_wr && w_in_range) ? w_merged : w_row_data;
`else
    // Read-before-write: the read sees the row as it was before this edge.
    assign w_rd_data = w_row_data;
`endif

    // FSM state register and clear counter.
    always_ff @(posedge Clk) begin
        if (!nReset) begin
            r_state <= S_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_INIT) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // FSM next state. INIT leaves on the edge that clears the last row.
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        case (r_state)
            S_INIT: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_state_nxt = S_RUN;
            end
            default: begin
                w_state_nxt = S_INIT;
                w_busy      = 1'b1;
            end
        endcase
    end

    // Storage. A write on a reset edge is dropped. Out-of-range writes are
    // dropped as well.
    always_ff @(posedge Clk) begin
        if (nReset) begin
            if (r_state == S_INIT) begin
                r_mem[r_cnt] <= '0;
            end else if (w_wr && w_in_range) begin
                r_mem[w_row] <= w_merged;
            end
        end
    end

    // Read pipeline, output register and error flag. Reset discards
    // in-flight reads.
    always_ff @(posedge Clk) begin
        if (!nReset) begin
            r_pipe_vld <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                r_pipe_data[i] <= '0;
            end
            r_data_out <= '0;
            r_valid    <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            r_pipe_vld[0]  <= w_rd;
            r_pipe_data[0] <= w_rd_data;
            for (int i = 1; i < READ_LAT; i++) begin
                r_pipe_vld[i]  <= r_pipe_vld[i-1];
                r_pipe_data[i] <= r_pipe_data[i-1];
            end
            r_valid <= r_pipe_vld[READ_LAT-1];
            if (r_pipe_vld[READ_LAT-1]) begin
                r_data_out <= r_pipe_data[READ_LAT-1];
            end
            if ((w_rd || w_wr) && !w_in_range) begin
                r_addr_err <= 1'b1;
            end
        end
    end

    assign MemDataOut = r_data_out;
    assign MemValid   = r_valid;
    assign Busy       = w_busy;
    assign AddrErr    = r_addr_err;

endmodule
`default_nettype wire

// File: tb/tb_main_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_main_mem_ctrl
// Purpose  : Self-checking bench for main_mem_ctrl with the default
//            parameters. Expected read data is queued when a read is issued
//            and is compared when MemValid appears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_main_mem_ctrl;

    localparam int c_RL = 2;

    logic          Clk = 1'b0;
    logic          nReset = 1'b0;
    logic [15:0]   address = '0;
    logic          nRead = 1'b1;
    logic          nWrite = 1'b1;
    logic [255:0]  ExeDataOut = '0;
    logic [15:0]   LaneMask = '0;
    logic [255:0]  MemDataOut;
    logic          MemValid;
    logic          Busy;
    logic          AddrErr;

    main_mem_ctrl #(
        .DATA_W   (256),
        .LANE_W   (16),
        .DEPTH    (16),
        .SEL_ID   (4'd0),
        .READ_LAT (c_RL)
    ) u_dut (
        .Clk        (Clk),
        .nReset     (nReset),
        .address    (address),
        .nRead      (nRead),
        .nWrite     (nWrite),
        .ExeDataOut (ExeDataOut),
        .LaneMask   (LaneMask),
        .MemDataOut (MemDataOut),
        .MemValid   (MemValid),
        .Busy       (Busy),
        .AddrErr    (AddrErr)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [255:0] d;
        int           due;
    } exp_t;
    exp_t q[$];

    typedef struct {
        logic         rd;
        logic         wr;
        logic [15:0]  addr;
        logic [255:0] data;
        logic [15:0]  mask;
        logic [255:0] exp;
    } vec_t;
    vec_t tbl[18];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every MemValid must match the oldest queued read.
    always @(negedge Clk) begin
        if (MemValid === 1'b1) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid: got MemValid=1 at cycle %0d expected no strobe", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("read_data", MemDataOut, e.d);
                chk("read_latency", 256'(cyc), 256'(e.due));
            end
        end
    end

    // Drive one request for one edge; queue the expected data of a selected read.
    task automatic req(input logic rd, input logic wr, input logic [15:0] a,
                       input logic [255:0] d, input logic [15:0] m,
                       input logic [255:0] e, input bit push);
        exp_t x;
        @(negedge Clk);
        nRead = ~rd; nWrite = ~wr; address = a; ExeDataOut = d; LaneMask = m;
        @(posedge Clk);
        if (rd && push) begin
            x.d   = e;
            x.due = cyc + c_RL + 1;
            q.push_back(x);
        end
    endtask

    task automatic idle(input int n);
        @(negedge Clk);
        nRead = 1'b1; nWrite = 1'b1; LaneMask = '0;
        repeat (n) @(posedge Clk);
    endtask

    // Releases reset and counts the edges on which Busy is still high.
    // Optionally checks that the output stays quiet and fires a write that
    // must be ignored.
    task automatic release_and_count(input bit quiet_chk, output int cnt);
        cnt = 0;
        @(negedge Clk);
        nReset = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (Busy !== 1'b1) break;
            cnt++;
            if (quiet_chk) begin
                chk("busy_dataout_zero", MemDataOut, 256'd0);
                chk("busy_no_valid", 256'(MemValid), 256'd0);
            end
            if (k == 2) begin
                nWrite = 1'b0; address = 16'h0000; ExeDataOut = '1; LaneMask = '1;
            end else begin
                nWrite = 1'b1;
            end
            @(negedge Clk);
        end
        nWrite = 1'b1;
    endtask

    logic [255:0] d3, a5, f5, mix, pat, ones, col_exp;
    int           busy_cnt;

    initial begin
        for (int i = 0; i < 16; i++) d3[i*16 +: 16] = 16'(16 - i);
        a5   = {16{16'hAAAA}};
        f5   = {16{16'h5555}};
        mix  = {{14{16'hAAAA}}, {2{16'h5555}}};
        pat  = {8{32'hDEADBEEF}};
        ones = '1;
`ifdef MAIN_MEM_FWD_EN
        col_exp = 256'd1;
`else
        col_exp = 256'd0;
`endif

        tbl[0]  = '{1'b0, 1'b1, 16'h0003, d3,   16'hFFFF, 256'd0};
        tbl[1]  = '{1'b1, 1'b0, 16'h0003, 256'd0, 16'h0000, d3};
        tbl[2]  = '{1'b0, 1'b1, 16'h0005, a5,   16'hFFFF, 256'd0};
        tbl[3]  = '{1'b0, 1'b1, 16'h0005, f5,   16'h0003, 256'd0};
        tbl[4]  = '{1'b1, 1'b0, 16'h0005, 256'd0, 16'h0000, mix};
        tbl[5]  = '{1'b0, 1'b1, 16'h1003, ones, 16'hFFFF, 256'd0};
        tbl[6]  = '{1'b1, 1'b0, 16'h0003, 256'd0, 16'h0000, d3};
        tbl[7]  = '{1'b1, 1'b0, 16'h0010, 256'd0, 16'h0000, 256'd0};
        tbl[8]  = '{1'b0, 1'b1, 16'h0010, ones, 16'hFFFF, 256'd0};
        tbl[9]  = '{1'b1, 1'b0, 16'h000F, 256'd0, 16'h0000, 256'd0};
        tbl[10] = '{1'b0, 1'b1, 16'h000F, pat,  16'hFFFF, 256'd0};
        tbl[11] = '{1'b1, 1'b0, 16'h000F, 256'd0, 16'h0000, pat};
        tbl[12] = '{1'b0, 1'b1, 16'h0009, ones, 16'h0000, 256'd0};
        tbl[13] = '{1'b1, 1'b0, 16'h0009, 256'd0, 16'h0000, 256'd0};
        tbl[14] = '{1'b1, 1'b0, 16'h0003, 256'd0, 16'h0000, d3};
        tbl[15] = '{1'b1, 1'b0, 16'h0005, 256'd0, 16'h0000, mix};
        tbl[16] = '{1'b1, 1'b0, 16'h1005, 256'd0, 16'h0000, 256'd0};
        tbl[17] = '{1'b1, 1'b0, 16'h0000, 256'd0, 16'h0000, 256'd0};

        // Reset held for three cycles.
        nReset = 1'b0;
        repeat (3) begin
            @(negedge Clk);
            chk("reset_busy", 256'(Busy), 256'd1);
            chk("reset_valid", 256'(MemValid), 256'd0);
            chk("reset_dataout", MemDataOut, 256'd0);
            chk("reset_addrerr", 256'(AddrErr), 256'd0);
        end

        // Clear sequence. A write issued while busy must be ignored.
        release_and_count(1'b0, busy_cnt);
        chk("busy_cycles", 256'(busy_cnt), 256'd16);
        chk("busy_low_after_clear", 256'(Busy), 256'd0);

        for (int r = 0; r < 16; r++) req(1'b1, 1'b0, 16'(r), '0, '0, 256'd0, 1'b1);
        idle(c_RL + 2);
        chk("addrerr_clean", 256'(AddrErr), 256'd0);

        // Table-driven transactions, back to back.
        for (int i = 0; i < 18; i++) begin
            req(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].mask,
                tbl[i].exp, tbl[i].addr[15:12] == 4'h0);
        end
        idle(c_RL + 2);
        chk("addrerr_set", 256'(AddrErr), 256'd1);

        // Same-row read and write in one cycle, then read back.
        req(1'b1, 1'b1, 16'h0007, 256'd1, 16'hFFFF, col_exp, 1'b1);
        req(1'b1, 1'b0, 16'h0007, 256'd0, 16'h0000, 256'd1, 1'b1);
        idle(c_RL + 2);
        chk("queue_drained_mid", 256'(q.size()), 256'd0);

        // Reset one edge after a read is accepted; that read must vanish.
        req(1'b1, 1'b0, 16'h0003, 256'd0, 16'h0000, 256'd0, 1'b0);
        @(negedge Clk);
        nRead = 1'b1; nWrite = 1'b1; nReset = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("reset2_addrerr", 256'(AddrErr), 256'd0);
        chk("reset2_dataout", MemDataOut, 256'd0);
        release_and_count(1'b1, busy_cnt);
        chk("busy_cycles_2", 256'(busy_cnt), 256'd16);

        // Rows were cleared again.
        req(1'b1, 1'b0, 16'h0003, 256'd0, 16'h0000, 256'd0, 1'b1);
        req(1'b1, 1'b0, 16'h000F, 256'd0, 16'h0000, 256'd0, 1'b1);
        idle(c_RL + 4);
        chk("queue_drained_end", 256'(q.size()), 256'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
